// File: rtl/matmul_pkg.sv
// Shared types and sizing for the 2x2 matmul streaming front/back end.
package matmul_pkg;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    DRAIN
  } state_t;

  // Elements per job (A then B) and results per job (C).
  localparam int unsigned N_ELEM = 8;
  localparam int unsigned N_RES  = 4;
  localparam int unsigned CNT_W  = $clog2(N_ELEM);
  localparam int unsigned IDX_W  = $clog2(N_RES);

  // Full-precision width of one result element for a given operand width.
  function automatic int unsigned res_width(input int unsigned bit_prec);
    return 2 * bit_prec + 1;
  endfunction

endpackage

// File: rtl/matmul_res_ser.sv
// Four-entry result buffer and valid/ready serializer (C00, C01, C10, C11).
module matmul_res_ser
  import matmul_pkg::*;
#(
  parameter int unsigned RW = 17
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cap,
  input  logic signed [RW-1:0] cap_data [N_RES],
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic signed [RW-1:0] m_data,
  output logic                 m_last,
  output logic                 done_c
);

  logic signed [RW-1:0] res_q [N_RES];
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_nxt;
  logic                 take;

  assign take    = m_valid && m_ready;
  assign idx_nxt = idx_q + IDX_W'(1);
  assign done_c  = take && (idx_q == IDX_W'(N_RES - 1));

  // Result buffer, loaded once per job when the engine reports valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(N_RES); i++) res_q[i] <= '0;
    end else if (cap) begin
      res_q <= cap_data;
    end
  end

  // Output register: present buffer[idx], advance on each accepted beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      idx_q   <= '0;
    end else if (cap) begin
      m_valid <= 1'b1;
      m_data  <= cap_data[0];
      m_last  <= 1'b0;
      idx_q   <= '0;
    end else if (done_c) begin
      m_valid <= 1'b0;
      idx_q   <= '0;
    end else if (take) begin
      idx_q   <= idx_nxt;
      m_data  <= res_q[idx_nxt];
      m_last  <= (idx_nxt == IDX_W'(N_RES - 1));
    end
  end

endmodule

// File: rtl/matmul_2x2_stream.sv
// Stream-to-parallel front end and result serializer for the matmul_2x2 engine.
module matmul_2x2_stream
  import matmul_pkg::*;
#(
  parameter int unsigned BIT_PREC = 8,
  parameter int unsigned N        = 2,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [BIT_PREC-1:0] s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic signed [2*BIT_PREC:0] m_data,
  output logic                       m_last,
  output logic                       eng_start,
  output logic signed [BIT_PREC-1:0] eng_a [N][N],
  output logic signed [BIT_PREC-1:0] eng_b [N][N],
  input  logic signed [2*BIT_PREC:0] eng_c [N][N],
  input  logic                       eng_valid,
  output logic                       busy,
  output logic                       err_frame,
  output logic                       err_timeout,
  input  logic                       err_clr
);

  localparam int unsigned RW = res_width(BIT_PREC);
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  generate
    if (N != 2) begin : g_bad_n
      $fatal(1, "matmul_2x2_stream: only N=2 is supported");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             acc;
  logic             last_slot;
  logic             set_frame;
  logic             set_to;
  logic             cap;
  logic             done_c;
  logic signed [RW-1:0] res_in [N_RES];

  assign acc       = s_valid && s_ready;
  assign last_slot = (cnt_q == CNT_W'(N_ELEM - 1));

  // State, element counter and wait counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state: framing check in LOAD, engine watchdog in WAIT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    set_frame = 1'b0;
    set_to    = 1'b0;
    cap       = 1'b0;
    case (state_q)
      LOAD: begin
        if (acc) begin
          if (last_slot != s_last) begin
            set_frame = 1'b1;
            cnt_d     = '0;
          end else if (last_slot) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      START: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_valid) begin
          cap     = 1'b1;
          state_d = DRAIN;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          set_to  = 1'b1;
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      DRAIN: begin
        if (done_c) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Registered handshake/status outputs decoded from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_ready   <= 1'b1;
      busy      <= 1'b0;
      eng_start <= 1'b0;
    end else begin
      s_ready   <= (state_d == LOAD);
      busy      <= (state_d != LOAD);
      eng_start <= (state_d == START);
    end
  end

  // Sticky error flags; a set event beats a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (set_frame)    err_frame <= 1'b1;
      else if (err_clr) err_frame <= 1'b0;
      if (set_to)       err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  // Operand registers: written only on LOAD accepts, so stable while the engine runs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(N); i++) begin
        for (int j = 0; j < int'(N); j++) begin
          eng_a[i][j] <= '0;
          eng_b[i][j] <= '0;
        end
      end
    end else if (acc) begin
      if (cnt_q[2]) eng_b[cnt_q[1]][cnt_q[0]] <= s_data;
      else          eng_a[cnt_q[1]][cnt_q[0]] <= s_data;
    end
  end

  // Flatten C into output order C00, C01, C10, C11.
  always_comb begin
    res_in[0] = eng_c[0][0];
    res_in[1] = eng_c[0][1];
    res_in[2] = eng_c[1][0];
    res_in[3] = eng_c[1][1];
  end

  matmul_res_ser #(.RW(RW)) u_res_ser (
    .clk      (clk),
    .rstn     (rstn),
    .cap      (cap),
    .cap_data (res_in),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .done_c   (done_c)
  );

endmodule

// File: tb/tb_matmul_2x2_stream.sv
// Self-checking bench: engine stub, result-queue model, per-cycle output compare.
`timescale 1ns/1ps
module tb_matmul_2x2_stream;

  localparam int BP = 8;
  localparam int TO = 32;
  localparam int RW = 2 * BP + 1;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 s_valid, s_ready, s_last;
  logic signed [BP-1:0] s_data;
  logic                 m_valid, m_ready, m_last;
  logic signed [RW-1:0] m_data;
  logic                 eng_start, eng_valid;
  logic signed [BP-1:0] eng_a [2][2];
  logic signed [BP-1:0] eng_b [2][2];
  logic signed [RW-1:0] eng_c [2][2];
  logic                 busy, err_frame, err_timeout, err_clr;

  matmul_2x2_stream #(.BIT_PREC(BP), .N(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_c(eng_c),
    .eng_valid(eng_valid), .busy(busy), .err_frame(err_frame),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_last  = 0;
  int mv_rise = -1;
  int n_out   = 0;
  int n_starts = 0;
  int exp_starts = 0;
  int mr_mode = 0;
  bit eng_en  = 1'b1;
  int exp_q[$];
  bit lst_q[$];
  int out_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int logv(input int i);
    return (out_log.size() > i) ? out_log[i] : 32'h7fffffff;
  endfunction

  // Engine stub: samples start, answers with A*B six cycles later.
  initial begin
    int sa [2][2];
    int sb [2][2];
    bit same;
    eng_valid = 1'b0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) eng_c[i][j] = '0;
    forever begin
      @(posedge clk); #1;
      if (eng_start) begin
        n_starts++;
        if (eng_en) begin
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
              sa[i][j] = int'(eng_a[i][j]);
              sb[i][j] = int'(eng_b[i][j]);
            end
          repeat (6) @(posedge clk);
          #1;
          same = 1'b1;
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
              if (int'(eng_a[i][j]) != sa[i][j] || int'(eng_b[i][j]) != sb[i][j]) same = 1'b0;
          chk("operand_hold", longint'(same), 1);
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
              eng_c[i][j] = RW'(sa[i][0] * sb[0][j] + sa[i][1] * sb[1][j]);
          eng_valid = 1'b1;
          @(posedge clk); #1;
          eng_valid = 1'b0;
        end
      end
    end
  end

  // Sink backpressure: always ready, 1,0,0,1 pattern, or random.
  initial begin
    int ph = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mr_mode)
        1: begin m_ready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
        2: m_ready = 1'($urandom_range(1, 0));
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Output compare against the expected-result queue on every cycle.
  initial begin
    bit stalled = 1'b0;
    bit mv_prev = 1'b0;
    int prev_data = 0;
    bit prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stalled = 1'b0;
        mv_prev = 1'b0;
      end else begin
        chk("busy_vs_s_ready", longint'(busy), longint'(!s_ready));
        if (stalled) begin
          chk("valid_held_while_stalled", longint'(m_valid), 1);
          chk("data_held_while_stalled", longint'(m_data), longint'(prev_data));
          chk("last_held_while_stalled", longint'(m_last), longint'(prev_last));
        end
        if (m_valid) begin
          chk("s_ready_low_in_drain", longint'(s_ready), 0);
          if (!mv_prev) mv_rise = cyc;
          if (m_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_output", longint'(m_data), 32'h7fffffff);
            end else begin
              chk("m_data", longint'(m_data), longint'(exp_q.pop_front()));
              chk("m_last", longint'(m_last), longint'(lst_q.pop_front()));
            end
            out_log.push_back(int'(m_data));
            n_out++;
          end
        end
        stalled   = m_valid && !m_ready;
        prev_data = int'(m_data);
        prev_last = m_last;
        mv_prev   = m_valid;
      end
    end
  end

  task automatic send_elem(input int d, input bit last);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = BP'(d);
    s_last  = last;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("s_ready_wait_expired", 0, 1);
    @(posedge clk); #1;
    t_last  = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // mode 0: clean job, 1: s_last on 3rd element, 2: s_last missing on 8th.
  task automatic send_job(input int a[4], input int b[4], input int mode, input int gap);
    int e[8];
    int n;
    for (int i = 0; i < 4; i++) begin e[i] = a[i]; e[i+4] = b[i]; end
    if (mode == 0) begin
      exp_starts++;
      if (eng_en) begin
        exp_q.push_back(a[0]*b[0] + a[1]*b[2]); lst_q.push_back(1'b0);
        exp_q.push_back(a[0]*b[1] + a[1]*b[3]); lst_q.push_back(1'b0);
        exp_q.push_back(a[2]*b[0] + a[3]*b[2]); lst_q.push_back(1'b0);
        exp_q.push_back(a[2]*b[1] + a[3]*b[3]); lst_q.push_back(1'b1);
      end
    end
    n = (mode == 1) ? 3 : 8;
    for (int i = 0; i < n; i++) begin
      if (gap > 0) begin
        repeat ($urandom_range(gap, 0)) @(posedge clk);
        #1;
      end
      send_elem(e[i], (mode == 0) ? (i == 7) : ((mode == 1) ? (i == 2) : 1'b0));
    end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && s_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_wait_expired", longint'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a[4];
    int b[4];
    int base;
    int st0;
    bit ok;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; err_clr = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", longint'(s_ready), 1);
    chk("rst_m_valid", longint'(m_valid), 0);
    chk("rst_m_data", longint'(m_data), 0);
    chk("rst_m_last", longint'(m_last), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_eng_start", longint'(eng_start), 0);
    chk("rst_eng_a11", longint'(eng_a[1][1]), 0);
    chk("rst_eng_b00", longint'(eng_b[0][0]), 0);
    chk("rst_err_frame", longint'(err_frame), 0);
    chk("rst_err_timeout", longint'(err_timeout), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic job with literal results and start-to-valid latency.
    base = out_log.size();
    a = '{1, 2, 3, 4}; b = '{5, 6, 7, 8};
    send_job(a, b, 0, 0);
    wait_drain();
    chk("basic_latency", longint'(mv_rise - t_last), 7);
    chk("basic_c00", logv(base),     19);
    chk("basic_c01", logv(base + 1), 22);
    chk("basic_c10", logv(base + 2), 43);
    chk("basic_c11", logv(base + 3), 50);

    // Signed extremes.
    base = out_log.size();
    a = '{-128, -128, -128, -128}; b = '{-128, -128, -128, -128};
    send_job(a, b, 0, 0);
    wait_drain();
    for (int i = 0; i < 4; i++) chk("neg_extreme", logv(base + i), 32768);
    base = out_log.size();
    a = '{127, 127, 127, 127};
    send_job(a, b, 0, 0);
    wait_drain();
    for (int i = 0; i < 4; i++) chk("mixed_extreme", logv(base + i), -32512);

    // Backpressure 1,0,0,1 during drain.
    mr_mode = 1;
    base = n_out;
    a = '{3, -7, 11, 5}; b = '{-2, 9, 4, -6};
    send_job(a, b, 0, 0);
    wait_drain();
    chk("bp_count", longint'(n_out - base), 4);
    mr_mode = 0;

    // Framing error: early s_last.
    st0 = n_starts;
    a = '{9, 9, 9, 9}; b = a;
    send_job(a, b, 1, 0);
    chk("frame_early_err", longint'(err_frame), 1);
    chk("frame_early_s_ready", longint'(s_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("frame_early_no_start", longint'(n_starts), longint'(st0));
    pulse_clr();
    chk("frame_clr", longint'(err_frame), 0);
    a = '{2, 0, 0, 2}; b = '{1, 2, 3, 4};
    send_job(a, b, 0, 0);
    wait_drain();

    // Framing error: missing s_last.
    st0 = n_starts;
    send_job(a, b, 2, 0);
    chk("frame_late_err", longint'(err_frame), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("frame_late_no_start", longint'(n_starts), longint'(st0));
    a = '{-1, 4, 6, -3}; b = '{8, -5, 2, 7};
    send_job(a, b, 0, 0);
    wait_drain();
    chk("frame_late_still_set", longint'(err_frame), 1);
    pulse_clr();
    chk("frame_late_clr", longint'(err_frame), 0);

    // Timeout: the engine never answers.
    eng_en = 1'b0;
    send_job(a, b, 0, 0);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (err_timeout) begin ok = 1'b1; break; end
    end
    chk("timeout_seen", longint'(ok), 1);
    chk("timeout_latency", longint'(cyc - t_last), TO + 1);
    chk("timeout_s_ready", longint'(s_ready), 1);
    chk("timeout_m_valid", longint'(m_valid), 0);
    @(posedge clk); #1;
    pulse_clr();
    chk("timeout_clr", longint'(err_timeout), 0);
    eng_en = 1'b1;

    // Reset mid-drain after C01 is accepted.
    base = n_out;
    a = '{5, 1, -4, 2}; b = '{3, 3, -1, 6};
    send_job(a, b, 0, 0);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (n_out >= base + 2) begin ok = 1'b1; break; end
    end
    chk("reset_wait_c01", longint'(ok), 1);
    @(posedge clk); #2;
    rstn = 1'b0;
    exp_q.delete();
    lst_q.delete();
    #1;
    chk("reset_m_valid", longint'(m_valid), 0);
    chk("reset_s_ready", longint'(s_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("reset_no_more_out", longint'(n_out), longint'(base + 2));
    base = out_log.size();
    a = '{1, 2, 3, 4}; b = '{5, 6, 7, 8};
    send_job(a, b, 0, 0);
    wait_drain();
    chk("post_reset_c00", logv(base), 19);
    chk("post_reset_c11", logv(base + 3), 50);

    // Randomized jobs with input gaps and random backpressure.
    mr_mode = 2;
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < 4; i++) begin
        a[i] = int'($urandom_range(255, 0)) - 128;
        b[i] = int'($urandom_range(255, 0)) - 128;
      end
      send_job(a, b, 0, 2);
    end
    wait_drain();
    mr_mode = 0;

    chk("start_count", longint'(n_starts), longint'(exp_starts));
    chk("final_err_frame", longint'(err_frame), 0);
    chk("final_err_timeout", longint'(err_timeout), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_2x2_stream.md
# matmul_2x2_stream

Streaming front/back end for the `matmul_2x2` Strassen engine. It collects A and B elements one at a time from a valid/ready input stream and drives the engine's parallel A/B ports and `start` pulse. It then captures C when the engine raises `valid` and returns the four results on a valid/ready output stream. It sits between the DMA/stream fabric and the engine, and owns the engine's start/valid handshake.

## Interface
- `BIT_PREC`, default 8: signed element width of A and B.
- `N`, default 2: matrix dimension. Only 2 is supported; any other value is an elaboration error.
- `TIMEOUT`, default 32: number of WAIT-state cycles allowed before the engine is declared hung.
- `clk`, input, 1: clock.
- `rstn`, input, 1: reset, asynchronous, active-low. Clock is clk.
- `s_valid`, input, 1: input element valid.
- `s_ready`, output, 1: input element ready.
- `s_data`, input, BIT_PREC signed: input element.
- `s_last`, input, 1: marks the 8th element of a job.
- `m_valid`, output, 1: result valid.
- `m_ready`, input, 1: result ready.
- `m_data`, output, 2*BIT_PREC+1 signed: result element.
- `m_last`, output, 1: marks C[1][1].
- `eng_start`, output, 1: engine start pulse.
- `eng_a`, output, BIT_PREC signed, [N][N]: A operand to the engine.
- `eng_b`, output, BIT_PREC signed, [N][N]: B operand to the engine.
- `eng_c`, input, 2*BIT_PREC+1 signed, [N][N]: engine result.
- `eng_valid`, input, 1: engine result pulse.
- `busy`, output, 1: high in every state except LOAD.
- `err_frame`, output, 1: sticky; set by a framing error.
- `err_timeout`, output, 1: sticky; set by an engine timeout.
- `err_clr`, input, 1: synchronous clear of both error flags.

## Operation
- Input order per job: A00, A01, A10, A11, B00, B01, B10, B11.
- Output order per job: C00, C01, C10, C11.
- States and transitions:
  - LOAD: `s_ready`=1. Each s_valid&&s_ready handshake writes `eng_a`/`eng_b` at index cnt, then cnt++.
  - LOAD, accept at cnt=7 with s_last=1: go to START.
  - LOAD, framing error: s_last=1 at cnt<7, or s_last=0 at cnt=7. The job is discarded, cnt=0, `err_frame` is set, state stays LOAD.
  - START: `eng_start`=1 for exactly one cycle, wait counter cleared, go to WAIT.
  - WAIT: on eng_valid=1, capture `eng_c` into the output buffer and go to DRAIN.
  - WAIT: when the wait counter reaches TIMEOUT-1 with no eng_valid, set `err_timeout` and go to LOAD with cnt=0.
  - DRAIN: `m_valid`=1, `m_data`=buffer[idx], `m_last`=(idx==3). Each handshake does idx++. The handshake at idx=3 goes to LOAD.
- `eng_a`/`eng_b` change only in LOAD, so they are held stable from `eng_start` through `eng_valid`. The engine requires this.
- eng_valid outside WAIT is ignored.
- `err_clr` and a set event in the same cycle: set wins.
- No arithmetic in this block. Results pass through unchanged at full 2*BIT_PREC+1 width.
- Reset values: state LOAD, cnt 0, idx 0, `s_ready` 1, `m_valid` 0, `m_data` 0, `m_last` 0, `eng_start` 0, `eng_a`/`eng_b` all 0, `busy` 0, both error flags 0.
- Reset mid-job from any state: the partial job or undelivered results are dropped with no output.

## Timing
- All outputs are registered or decoded from state only. There are no combinational paths from input to output; `s_ready` is state==LOAD.
- Last input accepted at edge T: `eng_start` is high in the cycle T..T+1.
- The engine samples start at T+1 and pulses eng_valid in the cycle T+6..T+7.
- Capture happens at T+7, and `m_valid` is first high in the cycle after T+7.
- With m_ready held at 1: 4 output cycles, then `s_ready` returns. Job period is 8 + 1 + 6 + 4 = 19 cycles.
- Under m_ready=0, `m_data`/`m_last` hold stable while `m_valid`=1.

## Structure
- Shared package `matmul_pkg`: state enum `{LOAD, START, WAIT, DRAIN}`, element count constant (8), result count constant (4), element widths derived from BIT_PREC.
- Natural sub-module `matmul_res_ser`: the 4-entry result buffer plus the valid/ready serializer with idx and last generation.
- The engine is instantiated beside this block at top level, not inside it.

## Test plan
- Basic job: A=[[1,2],[3,4]], B=[[5,6],[7,8]] streamed back-to-back, with a real engine attached. Required: outputs 19, 22, 43, 50; m_last only on 50; `m_valid` high exactly 7 edges after the last accept.
- Signed extremes: all A and B elements = -128. Required: four outputs of 32768 with no overflow. Also A=127 and B=-128 everywhere. Required: four outputs of -32512.
- Backpressure: m_ready toggled 1,0,0,1,… during DRAIN. Required: data holds while stalled, no duplicated or lost element, `s_ready`=0 until C11 is accepted.
- Framing errors:
  - s_last on the 3rd element: `err_frame`=1, no `eng_start`; the following clean job still gives correct results.
  - s_last missing on the 8th element: same required response.
- Timeout: engine stub never pulses valid. Required: `err_timeout`=1 after TIMEOUT cycles, state LOAD, `m_valid` stays 0; `err_clr` then clears it.
- Reset mid-DRAIN after C01 is accepted. Required: `m_valid`=0 immediately, `s_ready`=1, no further outputs; the next job produces correct results.
